// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet CRC-32 and frame-length constants
package eth_pkg;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    localparam int ETH_MIN_FRAME = 64;
    localparam int ETH_MAX_FRAME = 1518;
    localparam int ETH_FCS_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_STREAM
    } fcs_state_t;

endpackage

// File: rtl/lfsr.sv
// rtl/lfsr.sv - generic combinational LFSR/CRC step over DATA_WIDTH input bits
module lfsr #(
    parameter int                    LFSR_WIDTH  = 32,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = LFSR_WIDTH'(32'h04C11DB7),
    parameter                        LFSR_CONFIG = "GALOIS",
    parameter bit                    REVERSE     = 1'b1,
    parameter int                    DATA_WIDTH  = 8
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LFSR_WIDTH-1:0] state_in,
    output logic [LFSR_WIDTH-1:0] state_out
);

    localparam bit GALOIS = (LFSR_CONFIG == "GALOIS");

    logic [LFSR_WIDTH-1:0] st;
    logic [LFSR_WIDTH-1:0] poly_r;
    logic                  fb;

    // REVERSE shifts LSB-first with the bit-reflected polynomial
    always_comb begin
        st     = state_in;
        fb     = 1'b0;
        poly_r = '0;
        for (int i = 0; i < LFSR_WIDTH; i++) begin
            poly_r[i] = LFSR_POLY[LFSR_WIDTH-1-i];
        end
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (REVERSE) begin
                if (GALOIS) begin
                    fb = st[0] ^ data_in[i];
                    st = st >> 1;
                    if (fb) st = st ^ poly_r;
                end else begin
                    fb = (^(st & poly_r)) ^ data_in[i];
                    st = {fb, st[LFSR_WIDTH-1:1]};
                end
            end else begin
                if (GALOIS) begin
                    fb = st[LFSR_WIDTH-1] ^ data_in[DATA_WIDTH-1-i];
                    st = st << 1;
                    if (fb) st = st ^ LFSR_POLY;
                end else begin
                    fb = (^(st & LFSR_POLY)) ^ data_in[DATA_WIDTH-1-i];
                    st = {st[LFSR_WIDTH-2:0], fb};
                end
            end
        end
        state_out = st;
    end

endmodule

// File: rtl/eth_fcs_check.sv
// rtl/eth_fcs_check.sv - RX FCS check: CRC-32 residue test, FCS strip, length checks
module eth_fcs_check
    import eth_pkg::*;
#(
    parameter int MIN_FRAME_LEN = ETH_MIN_FRAME,
    parameter int MAX_FRAME_LEN = ETH_MAX_FRAME,
    parameter int LEN_WIDTH     = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    input  logic       s_error,
    output logic [7:0] m_data,
    output logic       m_valid,
    output logic       m_last,
    output logic       m_user,
    output logic       stat_ok,
    output logic       stat_crc_err,
    output logic       stat_len_err
);

    localparam logic [LEN_WIDTH-1:0] LEN_SAT = '1;
    localparam logic [LEN_WIDTH-1:0] MIN_L   = LEN_WIDTH'(MIN_FRAME_LEN);
    localparam logic [LEN_WIDTH-1:0] MAX_L   = LEN_WIDTH'(MAX_FRAME_LEN);
    localparam logic [2:0]           FULL    = 3'(ETH_FCS_BYTES);

    fcs_state_t           state_q, state_d;
    logic [2:0]           cnt_q, cnt_d;
    logic [31:0]          crc_q, crc_d, crc_next;
    logic [3:0][7:0]      dly_q, dly_d;
    logic [LEN_WIDTH-1:0] len_q, len_d, len_inc;
    logic                 err_q, err_d;
    logic                 emit, crc_bad, len_bad, frame_bad;
    logic [7:0]           m_data_d;
    logic                 m_valid_d, m_last_d, m_user_d;
    logic                 ok_d, crc_err_d, len_err_d;

    lfsr #(
        .LFSR_WIDTH (32),
        .LFSR_POLY  (CRC32_POLY),
        .LFSR_CONFIG("GALOIS"),
        .REVERSE    (1'b1),
        .DATA_WIDTH (8)
    ) u_crc (
        .data_in  (s_data),
        .state_in (crc_q),
        .state_out(crc_next)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        crc_d     = crc_q;
        dly_d     = dly_q;
        len_d     = len_q;
        err_d     = err_q;
        m_data_d  = dly_q[3];
        m_valid_d = 1'b0;
        m_last_d  = 1'b0;
        m_user_d  = 1'b0;
        ok_d      = 1'b0;
        crc_err_d = 1'b0;
        len_err_d = 1'b0;

        emit      = (state_q == ST_STREAM);
        len_inc   = (len_q == LEN_SAT) ? len_q : len_q + 1'b1;
        crc_bad   = (crc_next != CRC32_RESIDUE);
        // A frame whose s_last arrives before the delay line is full is a runt
        len_bad   = !emit || (len_inc > MAX_L) ||
                    ((MIN_FRAME_LEN != 0) && (len_inc < MIN_L));
        frame_bad = len_bad || crc_bad || err_q || s_error;

        if (s_valid) begin
            dly_d     = {dly_q[2:0], s_data};
            m_valid_d = emit;
            if (s_last) begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                crc_d     = CRC32_INIT;
                len_d     = '0;
                err_d     = 1'b0;
                m_last_d  = emit;
                m_user_d  = emit && frame_bad;
                len_err_d = len_bad;
                crc_err_d = !len_bad && crc_bad;
                ok_d      = !len_bad && !crc_bad && !err_q && !s_error;
            end else begin
                crc_d = crc_next;
                len_d = len_inc;
                err_d = err_q || s_error;
                if (!emit) begin
                    cnt_d   = cnt_q + 3'd1;
                    state_d = (cnt_q + 3'd1 == FULL) ? ST_STREAM : ST_FILL;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            crc_q        <= CRC32_INIT;
            dly_q        <= '0;
            len_q        <= '0;
            err_q        <= 1'b0;
            m_data       <= '0;
            m_valid      <= 1'b0;
            m_last       <= 1'b0;
            m_user       <= 1'b0;
            stat_ok      <= 1'b0;
            stat_crc_err <= 1'b0;
            stat_len_err <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            crc_q        <= crc_d;
            dly_q        <= dly_d;
            len_q        <= len_d;
            err_q        <= err_d;
            m_data       <= m_data_d;
            m_valid      <= m_valid_d;
            m_last       <= m_last_d;
            m_user       <= m_user_d;
            stat_ok      <= ok_d;
            stat_crc_err <= crc_err_d;
            stat_len_err <= len_err_d;
        end
    end

endmodule

// File: tb/tb_eth_fcs_check.sv
// tb/tb_eth_fcs_check.sv - scoreboard bench for eth_fcs_check (default and MIN_FRAME_LEN=0)
module tb_eth_fcs_check;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] s_data;
    logic       s_valid, s_last, s_error;

    logic [7:0] m_data [2];
    logic       m_valid [2];
    logic       m_last [2];
    logic       m_user [2];
    logic       stat_ok [2];
    logic       stat_crc_err [2];
    logic       stat_len_err [2];

    always #5 clk = ~clk;

    eth_fcs_check u_dut_def (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_error(s_error), .m_data(m_data[0]), .m_valid(m_valid[0]), .m_last(m_last[0]),
        .m_user(m_user[0]), .stat_ok(stat_ok[0]), .stat_crc_err(stat_crc_err[0]),
        .stat_len_err(stat_len_err[0])
    );

    eth_fcs_check #(.MIN_FRAME_LEN(0)) u_dut_nomin (
        .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_error(s_error), .m_data(m_data[1]), .m_valid(m_valid[1]), .m_last(m_last[1]),
        .m_user(m_user[1]), .stat_ok(stat_ok[1]), .stat_crc_err(stat_crc_err[1]),
        .stat_len_err(stat_len_err[1])
    );

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [1:0] user;
    } beat_t;

    beat_t      exp_q[$];
    logic [7:0] fr[$];
    logic       pend_v;
    logic [2:0] pend_stat [2];
    int         tests = 0;
    int         fails = 0;

    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    function automatic int min_len(input int k);
        return (k == 0) ? 64 : 0;
    endfunction

    task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s dut%0d observed=%h expected=%h", tag, k, obs, expv);
        end
    endtask

    // Check what the previous cycle produced, then drive the next cycle
    task automatic step(input logic v, input logic [7:0] d, input logic l, input logic e, input logic r);
        beat_t b;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check("m_valid", k, 32'(m_valid[k]), 32'(pend_v));
            check("stat", k, 32'({stat_ok[k], stat_crc_err[k], stat_len_err[k]}), 32'(pend_stat[k]));
        end
        if (m_valid[0] === 1'b1 || m_valid[1] === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 0, 32'(exp_q.size()), 32'd1);
            end else begin
                b = exp_q.pop_front();
                for (int k = 0; k < 2; k++)
                    check("beat", k, 32'({m_data[k], m_last[k], m_user[k]}),
                          32'({b.data, b.last, b.user[k]}));
            end
        end
        rst     = r;
        s_valid = v;
        s_data  = d;
        s_last  = l;
        s_error = e;
        pend_v       = 1'b0;
        pend_stat[0] = 3'b000;
        pend_stat[1] = 3'b000;
    endtask

    task automatic send_frame(input int err_idx, input int abort_idx, input int gap_pct);
        int          n;
        logic [31:0] c;
        logic        err, crc_bad, lb;
        beat_t       b;
        n   = fr.size();
        c   = 32'hFFFFFFFF;
        err = 1'b0;
        for (int i = 0; i < n; i++) begin
            while ($urandom_range(99) < gap_pct)
                step(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b0);
            if (i == abort_idx) begin
                step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
                return;
            end
            step(1'b1, fr[i], (i == n - 1), (i == err_idx), 1'b0);
            err = err || (i == err_idx);
            c   = crc_upd(c, fr[i]);
            crc_bad = (c != 32'hDEBB20E3);
            if (i >= 4) begin
                pend_v = 1'b1;
                b.data = fr[i-4];
                b.last = (i == n - 1);
                b.user = 2'b00;
            end
            if (i == n - 1) begin
                for (int k = 0; k < 2; k++) begin
                    lb = (n <= 4) || (n > 1518) || ((min_len(k) != 0) && (n < min_len(k)));
                    b.user[k]    = lb || crc_bad || err;
                    pend_stat[k] = lb ? 3'b001 : crc_bad ? 3'b010 : err ? 3'b000 : 3'b100;
                end
            end
            if (i >= 4) exp_q.push_back(b);
        end
    endtask

    task automatic make_good(input int payload);
        logic [31:0] c;
        logic [7:0]  v;
        fr.delete();
        c = 32'hFFFFFFFF;
        for (int i = 0; i < payload; i++) begin
            v = 8'($urandom);
            fr.push_back(v);
            c = crc_upd(c, v);
        end
        c = ~c;
        for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
    endtask

    initial begin
        rst = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; s_error = 1'b0;
        pend_v = 1'b0; pend_stat[0] = 3'b000; pend_stat[1] = 3'b000;
        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // "123456789" + FCS: good for MIN=0, runt for default
        fr = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
               8'h26, 8'h39, 8'hF4, 8'hCB};
        send_frame(-1, -1, 0);
        fr[9] = 8'h27;
        send_frame(-1, -1, 0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // back-to-back minimum frames, then a 63-byte runt with gaps
        make_good(60); send_frame(-1, -1, 0);
        make_good(60); send_frame(-1, -1, 0);
        make_good(59); send_frame(-1, -1, 30);
        make_good(60); send_frame(-1, -1, 30);

        // 3-byte runt followed by a normal frame
        fr = '{8'hAA, 8'hBB, 8'hCC};
        send_frame(-1, -1, 0);
        make_good(60); send_frame(-1, -1, 0);

        // oversize, then PHY error on byte 10
        make_good(1515); send_frame(-1, -1, 0);
        make_good(60);   send_frame(10, -1, 10);

        // reset at byte 30, then a clean frame
        make_good(60); send_frame(-1, 30, 0);
        make_good(60); send_frame(-1, -1, 0);

        repeat (3) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        check("sb_leftover", 0, 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/eth_fcs_check.md
Name: eth_fcs_check

Overview:
- Receive-side Ethernet FCS checker. It is the counterpart to the transmit-path CRC32 generator.
- Takes the byte stream from the RX MAC/PHY framing logic (preamble/SFD already removed, FCS still attached) and runs the reflected CRC-32 over every byte, including the FCS.
- Strips the 4 FCS bytes and forwards the payload downstream with a per-frame error flag on the last beat.
- Sits between the RX deframer and the RX packet FIFO.

Parameters:
- MIN_FRAME_LEN, 64, minimum legal frame length in bytes including FCS. Shorter frames are flagged bad. 0 disables the check.
- MAX_FRAME_LEN, 1518, maximum legal length in bytes including FCS. Longer frames are flagged bad.
- LEN_WIDTH, 16, width of the internal length counter. The counter saturates.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- s_data  in  8  input byte, first byte of frame first
- s_valid  in  1  s_data valid. There is no backpressure; every valid beat is consumed.
- s_last  in  1  qualifies the final byte of the frame (last FCS byte)
- s_error  in  1  PHY rx_er seen on this beat; marks the frame bad
- m_data  out  8  payload byte
- m_valid  out  1  m_data valid
- m_last  out  1  final payload byte
- m_user  out  1  valid with m_last: 1 = frame bad (CRC, length or PHY error)
- stat_ok  out  1  one-cycle pulse: frame good
- stat_crc_err  out  1  one-cycle pulse: FCS mismatch
- stat_len_err  out  1  one-cycle pulse: runt or oversize (also asserted for frames of 4 bytes or fewer)

Behaviour:
- Reset: all outputs 0. CRC register = 32'hFFFFFFFF, byte buffer empty, length = 0, error latch = 0.
- CRC: reflected CRC-32, poly 32'h04C11DB7, init all-ones, 8 bits per beat. Identical configuration to the TX generator.
  - crc_next is computed combinationally from the CRC register and s_data.
  - The CRC register updates only on s_valid beats.
- Good-FCS criterion: on the s_last beat, the un-inverted crc_next equals 32'hDEBB20E3 (residue; equals 32'h2144DF1C after final inversion).
- FCS stripping uses a 4-byte delay line plus a fill count of 0..4.
  - On each s_valid beat, the new byte is pushed.
  - If the count was already 4, the oldest byte is emitted.
  - Output registers load on that beat, so latency is exactly 1 cycle from the pushing input beat to m_valid.
  - On the s_last beat, the byte emitted is the last payload byte and m_last = 1. The 4 remaining bytes (FCS) are discarded.
- States:
  - IDLE (count 0, no frame in progress).
  - FILL (count 1..3): no output.
  - STREAM (count 4): one output beat per input beat.
  - Any s_last beat returns to IDLE on the next cycle: CRC re-initialised, count 0, length 0, error latch cleared.
- Length counts input bytes including FCS and saturates at 2^LEN_WIDTH-1. Checks are evaluated with the s_last byte included.
- s_error on any beat of a frame sets an error latch, which is ORed into m_user on the last beat.
- m_user = crc_bad | len_bad | error_latch, registered alongside m_last.
- Status pulses are registered in the same cycle as m_last. Exactly one of stat_ok / stat_crc_err / stat_len_err asserts per frame, with priority len > crc > ok. A PHY-error-only frame pulses none of them.
- Runt at or below 4 bytes: s_last arrives in IDLE/FILL, or in IDLE on a 1-byte frame.
  - No m_valid beats are produced.
  - stat_len_err pulses.
  - State returns to IDLE.
- Back-to-back frames: the first byte of the next frame may arrive on the cycle immediately after s_last and is treated as byte 0 with a fresh CRC.
- s_valid = 0 gaps mid-frame are allowed. State holds and outputs deassert (m_valid = 0, pulses = 0).
- Reset mid-frame: the partial frame is dropped silently. No m_last or stat pulse is emitted. The next s_valid beat starts a new frame.
- s_last with s_valid = 0 is ignored.

Decomposition:
- Shared package eth_pkg:
  - CRC32_POLY = 32'h04C11DB7
  - CRC32_INIT = 32'hFFFFFFFF
  - CRC32_RESIDUE = 32'hDEBB20E3
  - ETH_MIN_FRAME = 64
  - ETH_MAX_FRAME = 1518
  - ETH_FCS_BYTES = 4
  - The TX generator is updated to use the same constants.
- One sub-module: the existing generic lfsr block, instantiated with GALOIS, REVERSE = 1, DATA_WIDTH = 8, for crc_next. Delay line, counters and FSM live in eth_fcs_check.

Test Plan:
- MIN_FRAME_LEN=0, payload "123456789" (31..39) + FCS 26 39 F4 CB → 9 beats out, m_last on 8'h39, m_user=0, stat_ok pulse, FCS not forwarded.
- Same frame with the FCS first byte changed to 27 → identical data out, m_user=1, stat_crc_err pulse.
- Default params, 60-byte payload plus correct FCS, sent back-to-back twice with no gap, then a 59+4 byte runt → two good frames with stat_ok each, then m_user=1 with stat_len_err. Random s_valid gaps are inserted; latency remains 1 cycle per beat.
- 3-byte frame (AA BB CC, s_last on CC) → no m_valid beats, stat_len_err pulse, next frame processed normally.
- 1519-byte frame with a valid FCS → m_user=1, stat_len_err. Valid 64-byte frame with s_error on byte 10 → m_user=1, no stat pulse.
- rst asserted for 1 cycle at byte 30 of a 64-byte frame, then a full valid frame → no m_last for the aborted frame, following frame good with stat_ok.
